fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/mips_pkg.sv | 20 ++
 rtl/fetch_npc.sv | 38 +++
 rtl/fetch_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg -- shared types and constants for the instruction fetch path.
//   fetch_state_t    : fetch controller FSM encoding
//   DEFAULT_RESET_PC : boot fetch address
//   WORD_W / IMM_W / JIDX_W : word, branch immediate and jump index widths
package mips_pkg;

  localparam int WORD_W = 32;
  localparam int IMM_W  = 16;
  localparam int JIDX_W = 26;

  localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_npc.sv
// fetch_npc -- combinational next-PC selection.
// Ports:
//   pc       in  current instruction address
//   br_taken in  branch resolved taken
//   br_off   in  signed word offset from pc+4
//   jmp      in  J-type jump (overrides br_taken)
//   jmp_idx  in  26-bit jump index
//   npc      out next fetch address (all arithmetic wraps mod 2^32)
module fetch_npc
  import mips_pkg::*;
(
  input  logic [WORD_W-1:0] pc,
  input  logic              br_taken,
  input  logic [IMM_W-1:0]  br_off,
  input  logic              jmp,
  input  logic [JIDX_W-1:0] jmp_idx,
  output logic [WORD_W-1:0] npc
);

  logic [WORD_W-1:0] pc_plus4;
  logic [WORD_W-1:0] br_tgt;
  logic [WORD_W-1:0] jmp_tgt;

  assign pc_plus4 = pc + 32'd4;

  // Offset is in words: sign-extend then scale by 4 before adding.
  assign br_tgt  = pc_plus4 + {{(WORD_W-IMM_W-2){br_off[IMM_W-1]}}, br_off, 2'b00};

  // Jump stays inside the 256 MB region of the delay-slot address.
  assign jmp_tgt = {pc_plus4[WORD_W-1:WORD_W-4], jmp_idx, 2'b00};

  always_comb begin
    npc = pc_plus4;
    if (jmp)           npc = jmp_tgt;
    else if (br_taken) npc = br_tgt;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- single-outstanding instruction fetch controller.
// FSM: IDLE (one bubble after reset) -> FETCH (request until ack)
//      -> ISSUE (hold ir until advance) -> FETCH or HALT (terminal).
// Ports:
//   clk, rst              clock, async active-high reset
//   imem_req/addr         read request, address == pc
//   imem_ack/rdata        one-cycle response, data valid with ack
//   ir_valid, ir, pc      current instruction and its address
//   advance               consumer takes ir (ISSUE only)
//   br_taken, br_off      taken branch and word offset for ir
//   jmp, jmp_idx          J-type jump for ir (wins over branch)
//   halt, halted          stop after ir retires / stopped
// Optional FETCH_CTRL_PERF_EN adds fetch_cnt (accepted acks) and
// stall_cnt (ISSUE cycles with advance=0), both wrapping.
module fetch_ctrl
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic              ir_valid,
  output logic [WORD_W-1:0] ir,
  output logic [WORD_W-1:0] pc,
  input  logic              advance,
  input  logic              br_taken,
  input  logic [IMM_W-1:0]  br_off,
  input  logic              jmp,
  input  logic [JIDX_W-1:0] jmp_idx,
  input  logic              halt,
  output logic              halted
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [WORD_W-1:0] fetch_cnt,
  output logic [WORD_W-1:0] stall_cnt
`endif
);

  // Word alignment of the boot address is forced rather than trusted.
  localparam logic [WORD_W-1:0] BOOT_PC = {RESET_PC[WORD_W-1:2], 2'b00};

  fetch_state_t      state, state_nxt;
  logic              ld_ir;   // accept ack: capture instruction
  logic              ld_pc;   // retire ir: move to next PC
  logic [WORD_W-1:0] npc;

  fetch_npc u_npc (
    .pc       (pc),
    .br_taken (br_taken),
    .br_off   (br_off),
    .jmp      (jmp),
    .jmp_idx  (jmp_idx),
    .npc      (npc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Outputs decode straight from state so reset clears them at once.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    halted    = 1'b0;
    ld_ir     = 1'b0;
    ld_pc     = 1'b0;
    unique case (state)
      IDLE:  state_nxt = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ld_ir     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (advance) begin
          ld_pc     = 1'b1;
          state_nxt = halt ? HALT : FETCH;
        end
      end
      HALT:    halted = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= BOOT_PC;
      ir       <= '0;
      ir_valid <= 1'b0;
    end else begin
      if (ld_ir) begin
        ir       <= imem_rdata;
        ir_valid <= 1'b1;
      end
      if (ld_pc) begin
        pc       <= npc;
        ir_valid <= 1'b0;
      end
    end
  end

  assign imem_addr = pc;

`ifdef FETCH_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (ld_ir)                       fetch_cnt <= fetch_cnt + 32'd1;
      if (state == ISSUE && !advance)  stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
